// File: rtl/mem_responder_pkg.sv
// Shared core types for the memory responder: data word, access-size
// encodings, responder FSM states and a few decode helpers.
package mem_responder_pkg;

  typedef logic [31:0] word_t;

  // Access size/sign encoding carried on the request size field
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_addr_t;

  // Responder transaction states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } resp_state_t;

  // Wide enough to hold LATENCY-1 for LATENCY up to 4
  localparam int unsigned CNT_W = 2;

  // True for the five defined size encodings
  function automatic logic size_is_legal(input logic [2:0] size);
    case (size)
      MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // True when the low address bits do not match the natural alignment
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_H, MEM_HU: return addr_lo[0];
      MEM_W:         return (addr_lo != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_lane_align.sv
// Combinational lane steering: byte write enables and store-data
// replication on the way out, lane extraction and sign/zero extension
// on the way back.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [1:0] i_addr_lo,
  input  logic [2:0] i_size,
  input  word_t      i_wdata,
  input  word_t      i_rdata,
  output logic [3:0] o_we,
  output word_t      o_wdata,
  output word_t      o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: pick enabled byte lanes and replicate data across them
  always_comb begin
    o_we    = 4'b0000;
    o_wdata = 32'h0000_0000;
    case (i_size)
      MEM_B, MEM_BU: begin
        o_we    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      MEM_H, MEM_HU: begin
        o_we    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      MEM_W: begin
        o_we    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_we    = 4'b0000;
        o_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load side: select the addressed lane, then extend to a full word
  always_comb begin
    w_byte  = 8'h00;
    w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_rdata = 32'h0000_0000;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    case (i_size)
      MEM_B:   o_rdata = {{24{w_byte[7]}}, w_byte};
      MEM_BU:  o_rdata = {24'h00_0000, w_byte};
      MEM_H:   o_rdata = {{16{w_half[15]}}, w_half};
      MEM_HU:  o_rdata = {16'h0000, w_half};
      MEM_W:   o_rdata = i_rdata;
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder in front of a fixed-latency
// SRAM. Requests are decoded and issued in the accept cycle; loads wait
// LATENCY cycles for read data, then every transaction produces a
// one-cycle response pulse with registered data/error.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic              i_req_write,
  input  word_t             i_req_addr,
  input  logic [2:0]        i_req_size,
  input  word_t             i_req_wdata,
  output logic              o_req_ready,
  output logic              o_resp_valid,
  output word_t             o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_sram_en,
  output logic [3:0]        o_sram_we,
  output logic [ADDR_W-3:0] o_sram_addr,
  output word_t             o_sram_wdata,
  input  word_t             i_sram_rdata
);

  resp_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_addr_lo;
  logic [2:0]       r_size;
  logic             r_resp_err;
  word_t            r_resp_rdata;

  resp_state_t      w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic [1:0]       w_next_addr_lo;
  logic [2:0]       w_next_size;
  logic             w_next_resp_err;
  word_t            w_next_resp_rdata;

  logic             w_err;
  logic             w_out_of_range;
  logic             w_bad_store;
  logic [1:0]       w_align_addr_lo;
  logic [2:0]       w_align_size;
  logic [3:0]       w_lane_we;
  word_t            w_lane_wdata;
  word_t            w_lane_rdata;

  // In IDLE the aligner steers the incoming store; afterwards it decodes
  // the latched load attributes against the returning read data.
  assign w_align_addr_lo = (r_state == ST_IDLE) ? i_req_addr[1:0] : r_addr_lo;
  assign w_align_size    = (r_state == ST_IDLE) ? i_req_size      : r_size;

  mem_lane_align u_lane_align (
    .i_addr_lo (w_align_addr_lo),
    .i_size    (w_align_size),
    .i_wdata   (i_req_wdata),
    .i_rdata   (i_sram_rdata),
    .o_we      (w_lane_we),
    .o_wdata   (w_lane_wdata),
    .o_rdata   (w_lane_rdata)
  );

  // Request error decode: bad size, store of unsigned size, misalignment, range
  always_comb begin
    w_out_of_range = |i_req_addr[31:ADDR_W];
    w_bad_store    = i_req_write && ((i_req_size == MEM_BU) || (i_req_size == MEM_HU));
    w_err          = !size_is_legal(i_req_size) || w_bad_store ||
                     is_misaligned(i_req_size, i_req_addr[1:0]) || w_out_of_range;
  end

  // Next-state, SRAM strobes and handshake outputs
  always_comb begin
    w_next_state      = r_state;
    w_next_cnt        = r_cnt;
    w_next_addr_lo    = r_addr_lo;
    w_next_size       = r_size;
    w_next_resp_err   = r_resp_err;
    w_next_resp_rdata = r_resp_rdata;
    o_req_ready       = 1'b0;
    o_resp_valid      = 1'b0;
    o_sram_en         = 1'b0;
    o_sram_we         = 4'b0000;
    o_sram_addr       = '0;
    o_sram_wdata      = 32'h0000_0000;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        // Accepting is blocked while reset is held so no strobe escapes
        if (i_req_valid && i_rst_n) begin
          w_next_addr_lo = i_req_addr[1:0];
          w_next_size    = i_req_size;
          if (w_err) begin
            w_next_state      = ST_RESP;
            w_next_resp_err   = 1'b1;
            w_next_resp_rdata = 32'h0000_0000;
          end else if (i_req_write) begin
            o_sram_en         = 1'b1;
            o_sram_we         = w_lane_we;
            o_sram_addr       = i_req_addr[ADDR_W-1:2];
            o_sram_wdata      = w_lane_wdata;
            w_next_state      = ST_RESP;
            w_next_resp_err   = 1'b0;
            w_next_resp_rdata = 32'h0000_0000;
          end else begin
            o_sram_en    = 1'b1;
            o_sram_addr  = i_req_addr[ADDR_W-1:2];
            w_next_state = ST_WAIT;
            w_next_cnt   = CNT_W'(LATENCY - 1);
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_next_resp_rdata = w_lane_rdata;
          w_next_resp_err   = 1'b0;
          w_next_state      = ST_RESP;
        end else begin
          w_next_cnt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State and response registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_addr_lo    <= 2'b00;
      r_size       <= 3'b000;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_addr_lo    <= w_next_addr_lo;
      r_size       <= w_next_size;
      r_resp_err   <= w_next_resp_err;
      r_resp_rdata <= w_next_resp_rdata;
    end
  end

  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 16: byte-address width decoded by the backing SRAM; legal range 4..30.
REQ-002 Parameter LATENCY, default 1: SRAM read latency in cycles; legal range 1..4.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  core presents a request.
REQ-006 req_write  input  1  1=store, 0=load.
REQ-007 req_addr  input  32  byte address (word_t).
REQ-008 req_size  input  3  access size/sign (mem_addr_t: B=000, H=001, W=010, BU=100, HU=101).
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-013 resp_err  output  1  qualified by resp_valid; misaligned, illegal size or out-of-range access.
REQ-014 sram_en  output  1  SRAM access strobe.
REQ-015 sram_we  output  4  per-byte write enables; 0 on reads.
REQ-016 sram_addr  output  ADDR_W-2  word address.
REQ-017 sram_wdata  output  32  lane-aligned store data.
REQ-018 sram_rdata  input  32  read data, valid LATENCY cycles after sram_en with sram_we=0.

Function
REQ-019 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 Accept (IDLE, req_valid=1) SHALL latch addr, size, write, wdata and decode errors in the same cycle.
REQ-021 Error when: size not in {B,H,W,BU,HU}; store with BU/HU; H/HU with addr[0]=1; W with addr[1:0]!=0; any addr bit at or above ADDR_W set.
REQ-022 Errored accept: no sram_en; next state RESP with resp_err=1, resp_rdata=0.
REQ-023 Legal store: sram_en=1 and sram_we asserted in the accept cycle; B sets we bit addr[1:0], H sets bits {addr[1]*2+1, addr[1]*2}, W sets 4'b1111; wdata replicated into the addressed lanes; next state RESP.
REQ-024 Legal load: sram_en=1, sram_we=0 in the accept cycle; next state WAIT with counter loaded to LATENCY-1.
REQ-025 WAIT: decrement counter; when the counter is 0, capture sram_rdata, extract the lane by addr[1:0], sign-extend (B, H) or zero-extend (BU, HU) or pass through (W), and go to RESP.
REQ-026 RESP: resp_valid=1 for exactly one cycle, then IDLE; no response backpressure.
REQ-027 Load latency accept->resp_valid = LATENCY+1 cycles; store and error latency = 1 cycle.
REQ-028 A new request SHALL NOT be accepted in the RESP cycle; back-to-back throughput is one request per 2 cycles minimum.
REQ-029 sram_en and sram_we SHALL be 0 in every cycle except the accept cycle.
REQ-030 resp_rdata and resp_err SHALL be registered and held stable between responses.

Reset
REQ-031 rst_n=0 at a clock edge forces: state IDLE, counter 0, req_ready=1 on the next cycle, resp_valid=0, resp_err=0, resp_rdata=0, sram_en=0, sram_we=0.
REQ-032 Reset during WAIT or RESP SHALL abort the transaction silently, with no resp_valid; a store already issued is not rolled back.

Structure
REQ-033 mem_addr_t encodings and word_t SHALL come from the shared core package; the responder state enum (resp_state_t) SHALL also be added to that package.
REQ-034 Lane extraction/extension and write-enable/lane replication SHALL live in one combinational sub-module, mem_lane_align.

Verification
REQ-035 Scenario: store W 0xDEADBEEF at 0x10 -> sram_we=1111, sram_addr=4; then load W at 0x10 with LATENCY=1 -> resp_rdata=0xDEADBEEF two cycles after accept.
REQ-036 Scenario: store B 0x80 at 0x13, then load B at 0x13 -> 0xFFFFFF80; load BU at 0x13 -> 0x00000080; store cycle sram_we=1000.
REQ-037 Scenario: load H at 0x21 -> resp_err=1, resp_rdata=0, no sram_en; store HU at 0x20 -> resp_err=1.
REQ-038 Scenario: ADDR_W=16, load W at 0x00010000 -> resp_err=1 with no SRAM access.
REQ-039 Scenario: LATENCY=3, hold req_valid=1 continuously -> resp_valid 4 cycles after each accept; req_ready low from accept through RESP.
REQ-040 Scenario: rst_n=0 asserted in WAIT -> no resp_valid; all outputs at reset values; the next request completes normally.
